// File: rtl/uart_rx_os_ext.sv
// Oversampling UART receiver: sync + 3-sample vote, 5..9N/E/O 1/2, break detect,
// one-entry valid/ready buffer with overrun pulse. Ports: clk, rst_n, os_tick, rx_line
// in; data_out, valid, parity_error, framing_error, overrun, break_det out; ready in.
module uart_rx_os_ext #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] C_LO  = CW'(M - 1);
  localparam logic [CW-1:0] C_MID = CW'(M);
  localparam logic [CW-1:0] C_DEC = CW'(M + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_e;

  state_e state_q, state_d;

  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic [1:0]           smp_q, smp_d;
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stp_q, stp_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 brk_q, brk_d;

  logic rx_s, maj, at_dec, at_end;
  logic par_exp, is_brk, done, brk;

  assign rx_s   = sync_q[1];
  assign at_dec = os_tick && (cnt_q == C_DEC);
  assign at_end = os_tick && (cnt_q == C_END);
  assign maj    = (smp_q[0] & smp_q[1]) |
                  (smp_q[0] & rx_s) |
                  (smp_q[1] & rx_s);

  assign par_exp = (PARITY_MODE == 2) ? ~^shr_q : ^shr_q;

  // all-zero frame through the first stop bit
  assign is_brk = (shr_q == '0) &&
                  ((PARITY_MODE == 0) || !pbit_q) &&
                  !maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      smp_q   <= 2'b11;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stp_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_line};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      smp_q   <= smp_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stp_q   <= stp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (os_tick && !rx_s) state_d = S_START;
      S_START:
        if (at_dec && maj) state_d = S_IDLE;
        else if (at_end) state_d = S_DATA;
      S_DATA:
        if (at_end && bit_q == B_LAST)
          state_d = (PARITY_MODE != 0) ? S_PAR : S_STOP;
      S_PAR:
        if (at_end) state_d = S_STOP;
      S_STOP:
        if (at_dec) begin
          if (!stp_q && is_brk) state_d = S_BRK;
          else if (stp_q == S_LAST) state_d = S_IDLE;
        end
      S_BRK:
        if (os_tick && rx_s) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    shr_d  = shr_q;
    smp_d  = smp_q;
    pbit_d = pbit_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    stp_d  = stp_q;
    done   = 1'b0;
    brk    = 1'b0;

    if (os_tick) begin
      // counter runs only inside a frame and restarts on every exit
      if (state_q != S_IDLE && state_q != S_BRK &&
          state_d != S_IDLE && state_d != S_BRK)
        cnt_d = (cnt_q == C_END) ? '0 : cnt_q + CW'(1);
      else
        cnt_d = '0;
      if (cnt_q == C_LO)  smp_d[0] = rx_s;
      if (cnt_q == C_MID) smp_d[1] = rx_s;
    end

    unique case (state_q)
      S_IDLE:
        if (os_tick && !rx_s) begin
          bit_d  = '0;
          pbit_d = 1'b0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
          stp_d  = 1'b0;
        end
      S_DATA: begin
        if (at_dec) shr_d[bit_q] = maj;
        if (at_end) bit_d = bit_q + BW'(1);
      end
      S_PAR:
        if (at_dec) begin
          pbit_d = maj;
          perr_d = (maj != par_exp);
        end
      S_STOP: begin
        if (at_dec) begin
          ferr_d = ferr_q | ~maj;
          if (!stp_q && is_brk) brk = 1'b1;
          else if (stp_q == S_LAST) done = 1'b1;
        end
        if (at_end) stp_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    valid_d = valid_q & ~ready;
    ovr_d   = 1'b0;
    brk_d   = brk;
    if (done) begin
      if (!valid_q || ready) begin
        data_d  = shr_q;
        pe_d    = perr_q;
        fe_d    = ferr_q | ~maj;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data_out      = data_q;
  assign valid         = valid_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;
  assign overrun       = ovr_q;
  assign break_det     = brk_q;

endmodule

// File: tb/tb_uart_rx_os_ext.sv
// Bench for uart_rx_os_ext: four frame formats, directed cases plus random
// frames scored against a frame-level model of the receiver's rules.
module tb_uart_rx_os_ext;

  localparam int NK = 4;
  localparam int DB [NK] = '{8, 8, 8, 7};
  localparam int OS [NK] = '{16, 16, 16, 8};
  localparam int PM [NK] = '{0, 1, 2, 1};
  localparam int SB [NK] = '{1, 1, 2, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic os_tick = 1'b0;
  logic [NK-1:0] rx_l = '1;
  logic [NK-1:0] rdy = '1;
  logic [NK-1:0] vld, pe, fe, ov, bk;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [8:0] dout [NK];

  assign dout[0] = {1'b0, d0};
  assign dout[1] = {1'b0, d1};
  assign dout[2] = {1'b0, d2};
  assign dout[3] = {2'b0, d3};

  uart_rx_os_ext #(.DATA_BITS(8), .OVERSAMPLE(16),
    .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick),
    .rx_line(rx_l[0]), .data_out(d0), .valid(vld[0]),
    .ready(rdy[0]), .parity_error(pe[0]),
    .framing_error(fe[0]), .overrun(ov[0]),
    .break_det(bk[0]));

  uart_rx_os_ext #(.DATA_BITS(8), .OVERSAMPLE(16),
    .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick),
    .rx_line(rx_l[1]), .data_out(d1), .valid(vld[1]),
    .ready(rdy[1]), .parity_error(pe[1]),
    .framing_error(fe[1]), .overrun(ov[1]),
    .break_det(bk[1]));

  uart_rx_os_ext #(.DATA_BITS(8), .OVERSAMPLE(16),
    .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick),
    .rx_line(rx_l[2]), .data_out(d2), .valid(vld[2]),
    .ready(rdy[2]), .parity_error(pe[2]),
    .framing_error(fe[2]), .overrun(ov[2]),
    .break_det(bk[2]));

  uart_rx_os_ext #(.DATA_BITS(7), .OVERSAMPLE(8),
    .PARITY_MODE(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick),
    .rx_line(rx_l[3]), .data_out(d3), .valid(vld[3]),
    .ready(rdy[3]), .parity_error(pe[3]),
    .framing_error(fe[3]), .overrun(ov[3]),
    .break_det(bk[3]));

  always #5 clk = ~clk;

  // os_tick high on every other clock
  initial forever begin
    @(negedge clk);
    os_tick = ~os_tick;
  end

  int n_tot = 0;
  int n_bad = 0;

  int acc_cnt [NK] = '{default: 0};
  int brk_cnt [NK] = '{default: 0};
  int ovr_cnt [NK] = '{default: 0};
  logic [8:0] acc_d [NK];
  logic acc_pe [NK];
  logic acc_fe [NK];
  time vrise [NK];
  time stop_t [NK];
  logic [NK-1:0] vld_p = '0;

  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (vld[k] && rdy[k]) begin
        acc_cnt[k]++;
        acc_d[k]  = dout[k];
        acc_pe[k] = pe[k];
        acc_fe[k] = fe[k];
      end
      if (ov[k]) ovr_cnt[k]++;
      if (bk[k]) brk_cnt[k]++;
      if (vld[k] && !vld_p[k]) vrise[k] = $time;
    end
    vld_p = vld;
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    while (!os_tick) @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, logic v, int n);
    rx_l[k] = v;
    repeat (n) tick1();
  endtask

  task automatic send(int k, logic [8:0] data, logic pbit,
                      logic [1:0] stp, int gap, bit glitch);
    drive(k, 1'b0, OS[k]);
    for (int i = 0; i < DB[k]; i++) begin
      if (glitch && i == 3) begin
        drive(k, data[i], 9);
        drive(k, ~data[i], 1);
        drive(k, data[i], OS[k] - 10);
      end else begin
        drive(k, data[i], OS[k]);
      end
    end
    if (PM[k] != 0) drive(k, pbit, OS[k]);
    for (int s = 0; s < SB[k]; s++) begin
      if (s == SB[k] - 1) stop_t[k] = $time;
      drive(k, stp[s], OS[k]);
    end
    if (gap > 0) drive(k, 1'b1, gap);
  endtask

  // frame-level model: what the receiver must report for one frame
  task automatic check_frame(int k, logic [8:0] data, logic pbit,
                             logic [1:0] stp, int a0, int b0,
                             bit lat);
    logic [8:0] dm;
    logic par, ep, perr, ferr;
    bit isb;
    time t;
    int m;
    dm   = data & 9'((1 << DB[k]) - 1);
    isb  = (dm == 0) && (PM[k] == 0 || !pbit) && !stp[0];
    par  = ^dm;
    ep   = (PM[k] == 2) ? ~par : par;
    perr = (PM[k] != 0) && (pbit != ep);
    ferr = !stp[0] || (SB[k] == 2 && !stp[1]);
    if (isb) begin
      check($sformatf("brk%0d", k), brk_cnt[k] - b0, 1);
      check($sformatf("nodel%0d", k), acc_cnt[k] - a0, 0);
    end else begin
      check($sformatf("del%0d", k), acc_cnt[k] - a0, 1);
      check($sformatf("data%0d", k), acc_d[k], dm);
      check($sformatf("perr%0d", k), acc_pe[k], perr);
      check($sformatf("ferr%0d", k), acc_fe[k], ferr);
      check($sformatf("nobrk%0d", k), brk_cnt[k] - b0, 0);
      if (lat) begin
        m = OS[k] / 2;
        t = vrise[k] - stop_t[k];
        check($sformatf("lat%0d", k),
              (t > 20 * m) && (t < 20 * m + 120), 1);
      end
    end
  endtask

  task automatic frame(int k, logic [8:0] data, logic pbit,
                       logic [1:0] stp, int gap, bit glitch);
    int a0, b0;
    a0 = acc_cnt[k];
    b0 = brk_cnt[k];
    send(k, data, pbit, stp, gap, glitch);
    check_frame(k, data, pbit, stp, a0, b0, 1'b1);
  endtask

  initial begin
    int a0, b0, o0;
    logic [8:0] rd;
    logic rp;
    logic [1:0] rs;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      check($sformatf("rst_v%0d", k), vld[k], 0);
      check($sformatf("rst_d%0d", k), dout[k], 0);
      check($sformatf("rst_f%0d", k),
            {pe[k], fe[k], ov[k], bk[k]}, 0);
    end
    rst_n = 1'b1;
    repeat (8) tick1();

    // back-to-back 8N1
    frame(0, 9'hA5, 1'b0, 2'b11, 0, 1'b0);
    frame(0, 9'h3C, 1'b0, 2'b11, 16, 1'b0);

    // even and odd parity, both parity-bit values
    frame(1, 9'h07, 1'b1, 2'b11, 16, 1'b0);
    frame(1, 9'h07, 1'b0, 2'b11, 16, 1'b0);
    frame(2, 9'h07, 1'b1, 2'b11, 16, 1'b0);
    frame(2, 9'h07, 1'b0, 2'b11, 16, 1'b0);

    // second stop bit low: framing error, not a break
    frame(2, 9'h55, 1'b1, 2'b01, 32, 1'b0);

    // overrun with ready held low
    rdy[0] = 1'b0;
    a0 = acc_cnt[0];
    o0 = ovr_cnt[0];
    send(0, 9'h11, 1'b0, 2'b11, 16, 1'b0);
    check("ovr_none", ovr_cnt[0] - o0, 0);
    send(0, 9'h22, 1'b0, 2'b11, 16, 1'b0);
    check("ovr_vld", vld[0], 1);
    check("ovr_hold", dout[0], 9'h11);
    check("ovr_cnt", ovr_cnt[0] - o0, 1);
    check("ovr_noacc", acc_cnt[0] - a0, 0);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_drop", vld[0], 0);
    check("ovr_acc", acc_cnt[0] - a0, 1);
    check("ovr_accd", acc_d[0], 9'h11);

    // one-tick glitch at a data-bit midpoint
    frame(0, 9'h5A, 1'b0, 2'b11, 16, 1'b1);
    frame(0, 9'hA5, 1'b0, 2'b11, 16, 1'b1);

    // line held low for two frame times
    a0 = acc_cnt[0];
    b0 = brk_cnt[0];
    drive(0, 1'b0, 2 * 10 * 16);
    check("brk_one", brk_cnt[0] - b0, 1);
    check("brk_nodel", acc_cnt[0] - a0, 0);
    check("brk_vld", vld[0], 0);
    drive(0, 1'b1, 3 * 16);
    check("brk_quiet", brk_cnt[0] - b0, 1);
    check("brk_quiet_d", acc_cnt[0] - a0, 0);

    // 4-tick low pulse: false start
    a0 = acc_cnt[0];
    b0 = brk_cnt[0];
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 2 * 16);
    check("fs_nodel", acc_cnt[0] - a0, 0);
    check("fs_nobrk", brk_cnt[0] - b0, 0);
    check("fs_vld", vld[0], 0);

    // reset mid-frame with a frame parked in the buffer
    rdy[0] = 1'b0;
    send(0, 9'h3C, 1'b0, 2'b11, 16, 1'b0);
    check("rm_vld", vld[0], 1);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 3 * 16);
    rst_n = 1'b0;
    rx_l[0] = 1'b1;
    #3;
    check("rm_v", vld[0], 0);
    check("rm_d", dout[0], 0);
    check("rm_f", {pe[0], fe[0], ov[0], bk[0]}, 0);
    #20;
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    a0 = acc_cnt[0];
    drive(0, 1'b1, 2 * 10 * 16);
    check("rm_nodel", acc_cnt[0] - a0, 0);
    check("rm_v2", vld[0], 0);

    // random frames on every format
    for (int k = 0; k < NK; k++) begin
      for (int n = 0; n < 10; n++) begin
        rd = 9'($urandom) & 9'((1 << DB[k]) - 1);
        rp = ^rd;
        if (PM[k] == 2) rp = ~rp;
        if ($urandom_range(0, 3) == 0) rp = ~rp;
        rs[0] = ($urandom_range(0, 4) != 0);
        rs[1] = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 7) == 0) begin
          rd = '0;
          rp = 1'b0;
          rs[0] = 1'b0;
        end
        frame(k, rd, rp, rs, 2 * OS[k], 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
